// File: rtl/uart_param_loader_if.sv
// rtl/uart_param_loader_if.sv - received-byte strobe bus from the UART edge detector into the parameter loader

interface uart_param_loader_if;
   logic [7:0] byte_in;
   logic       byte_stb;

   modport master (output byte_in, output byte_stb);
   modport slave  (input  byte_in, input  byte_stb);
endinterface

// File: rtl/uart_param_loader.sv
// rtl/uart_param_loader.sv - framed UART writer for the PID parameter registers (KP, KI, KD, SETPOINT)
// Optional trailing XOR checksum byte enabled by defining PARAM_CHECKSUM_EN.

module uart_param_loader #(
   parameter int         DATA_W      = 16,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic                clk_in,
   input  logic                rst_in,
   uart_param_loader_if.slave  rx,
   output logic [DATA_W-1:0]   kp_out,
   output logic [DATA_W-1:0]   ki_out,
   output logic [DATA_W-1:0]   kd_out,
   output logic [DATA_W-1:0]   setpoint_out,
   output logic                param_upd,
   output logic                frame_err,
   output logic                busy
);

   localparam int NB = DATA_W / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC);

`ifdef PARAM_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
`endif

   state_t            state_q, state_d;
   logic [1:0]        addr_q, addr_d;
   logic [CW-1:0]     bcnt_q, bcnt_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] word_nxt;
   logic [DATA_W-1:0] wr_word;
   logic              wr_en;
   logic              upd_d;
   logic              err_d;
   logic              tmo_hit;
`ifdef PARAM_CHECKSUM_EN
   logic [7:0]        acc_q, acc_d;
`endif

   assign word_nxt = DATA_W'({shift_q, rx.byte_in});
   // Abort on the edge where the counter would reach TIMEOUT_CYC-1.
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 2));
   assign busy     = (state_q != S_IDLE);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      tmo_d   = '0;
      wr_en   = 1'b0;
      wr_word = shift_q;
      upd_d   = 1'b0;
      err_d   = 1'b0;
`ifdef PARAM_CHECKSUM_EN
      acc_d   = acc_q;
`endif
      if (rx.byte_stb) begin
         case (state_q)
            S_IDLE: begin
               if (rx.byte_in == SYNC_BYTE) begin
                  state_d = S_ADDR;
               end
            end
            S_ADDR: begin
               addr_d = rx.byte_in[1:0];
               bcnt_d = '0;
`ifdef PARAM_CHECKSUM_EN
               acc_d  = rx.byte_in;
`endif
               if (rx.byte_in > 8'd3) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               shift_d = word_nxt;
`ifdef PARAM_CHECKSUM_EN
               acc_d   = acc_q ^ rx.byte_in;
`endif
               if (bcnt_q == CW'(NB - 1)) begin
`ifdef PARAM_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  wr_en   = 1'b1;
                  wr_word = word_nxt;
                  upd_d   = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
`ifdef PARAM_CHECKSUM_EN
            S_CSUM: begin
               if (rx.byte_in == acc_q) begin
                  wr_en = 1'b1;
                  upd_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         addr_q       <= '0;
         bcnt_q       <= '0;
         tmo_q        <= '0;
         shift_q      <= '0;
         param_upd    <= 1'b0;
         frame_err    <= 1'b0;
         kp_out       <= '0;
         ki_out       <= '0;
         kd_out       <= '0;
         setpoint_out <= '0;
      end else begin
         addr_q    <= addr_d;
         bcnt_q    <= bcnt_d;
         tmo_q     <= tmo_d;
         shift_q   <= shift_d;
         param_upd <= upd_d;
         frame_err <= err_d;
         if (wr_en) begin
            case (addr_q)
               2'd0:    kp_out       <= wr_word;
               2'd1:    ki_out       <= wr_word;
               2'd2:    kd_out       <= wr_word;
               default: setpoint_out <= wr_word;
            endcase
         end
      end
   end

`ifdef PARAM_CHECKSUM_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_param_loader.sv
// tb/tb_uart_param_loader.sv - directed self-checking bench for uart_param_loader

module tb_uart_param_loader;

   localparam int DATA_W = 16;
   localparam int TMO    = 20;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic [DATA_W-1:0] kp_out, ki_out, kd_out, setpoint_out;
   logic              param_upd, frame_err, busy;

   int vec_cnt  = 0;
   int err_cnt  = 0;
   int upd_cnt  = 0;
   int both_cnt = 0;

   uart_param_loader_if rx ();

   uart_param_loader #(
      .DATA_W      (DATA_W),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rx           (rx),
      .kp_out       (kp_out),
      .ki_out       (ki_out),
      .kd_out       (kd_out),
      .setpoint_out (setpoint_out),
      .param_upd    (param_upd),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (param_upd) upd_cnt++;
      if (param_upd && frame_err) both_cnt++;
   end

   // Strobe one byte for exactly one cycle; returns 1ns after the sampling edge.
   task automatic drive(input logic [7:0] b);
      rx.byte_in  = b;
      rx.byte_stb = 1'b1;
      @(posedge clk_in);
      #1;
      rx.byte_stb = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic frame(input logic [7:0] addr, input logic [15:0] w);
      logic [7:0] cs;
      cs = addr ^ w[15:8] ^ w[7:0];
      drive(8'hA5);
      drive(addr);
      drive(w[15:8]);
      drive(w[7:0]);
`ifdef PARAM_CHECKSUM_EN
      drive(cs);
`endif
   endtask

   task automatic test_reset;
      rx.byte_in  = 8'h00;
      rx.byte_stb = 1'b0;
      rst_in      = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      vec_cnt++;
      if ({kp_out, ki_out, kd_out, setpoint_out} !== 64'h0) begin
         err_cnt++;
         $display("FAIL reset_regs: got %h want 0", {kp_out, ki_out, kd_out, setpoint_out});
      end
      vec_cnt++;
      if ({param_upd, frame_err, busy} !== 3'b000) begin
         err_cnt++;
         $display("FAIL reset_flags: got %b want 000", {param_upd, frame_err, busy});
      end
      rst_in = 1'b0;
      idle(1);
   endtask

   task automatic test_write;
      frame(8'h02, 16'h1234);
      vec_cnt++;
      if (param_upd !== 1'b1 || frame_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL write_upd: got upd=%b err=%b want upd=1 err=0", param_upd, frame_err);
      end
      vec_cnt++;
      if (kd_out !== 16'h1234 || {kp_out, ki_out, setpoint_out} !== 48'h0) begin
         err_cnt++;
         $display("FAIL write_kd: got kd=%h others=%h want kd=1234 others=0", kd_out, {kp_out, ki_out, setpoint_out});
      end
      idle(1);
      vec_cnt++;
      if (param_upd !== 1'b0 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL write_pulse_len: got upd=%b busy=%b want 0 0", param_upd, busy);
      end
   endtask

`ifdef PARAM_CHECKSUM_EN
   task automatic test_checksum;
      frame(8'h03, 16'hBEEF);
      vec_cnt++;
      if (setpoint_out !== 16'hBEEF || param_upd !== 1'b1) begin
         err_cnt++;
         $display("FAIL csum_good: got sp=%h upd=%b want BEEF 1", setpoint_out, param_upd);
      end
      drive(8'hA5);
      drive(8'h03);
      drive(8'h12);
      drive(8'h34);
      drive(8'h53);
      vec_cnt++;
      if (frame_err !== 1'b1 || param_upd !== 1'b0 || setpoint_out !== 16'hBEEF) begin
         err_cnt++;
         $display("FAIL csum_bad: got err=%b upd=%b sp=%h want 1 0 BEEF", frame_err, param_upd, setpoint_out);
      end
      idle(1);
   endtask
`endif

   task automatic test_bad_addr;
      drive(8'h11);
      vec_cnt++;
      if (busy !== 1'b0 || frame_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL garbage_ignored: got busy=%b err=%b want 0 0", busy, frame_err);
      end
      drive(8'hA5);
      vec_cnt++;
      if (busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL sync_busy: got %b want 1", busy);
      end
      drive(8'h07);
      vec_cnt++;
      if (frame_err !== 1'b1 || busy !== 1'b0 || param_upd !== 1'b0) begin
         err_cnt++;
         $display("FAIL bad_addr: got err=%b busy=%b upd=%b want 1 0 0", frame_err, busy, param_upd);
      end
      idle(1);
      vec_cnt++;
      if (frame_err !== 1'b0 || kd_out !== 16'h1234 || kp_out !== 16'h0) begin
         err_cnt++;
         $display("FAIL bad_addr_after: got err=%b kd=%h kp=%h want 0 1234 0", frame_err, kd_out, kp_out);
      end
   endtask

   task automatic test_timeout;
      drive(8'hA5);
      drive(8'h00);
      drive(8'h12);
      idle(TMO - 2);
      vec_cnt++;
      if (frame_err !== 1'b0 || busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL timeout_early: got err=%b busy=%b want 0 1", frame_err, busy);
      end
      idle(1);
      vec_cnt++;
      if (frame_err !== 1'b1 || busy !== 1'b0 || kp_out !== 16'h0) begin
         err_cnt++;
         $display("FAIL timeout_fire: got err=%b busy=%b kp=%h want 1 0 0", frame_err, busy, kp_out);
      end
      idle(1);
      vec_cnt++;
      if (frame_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_pulse_len: got %b want 0", frame_err);
      end
      drive(8'hA5);
      drive(8'h00);
      drive(8'h56);
      idle(TMO - 2);
      drive(8'h78);
`ifdef PARAM_CHECKSUM_EN
      drive(8'h2E);
`endif
      vec_cnt++;
      if (kp_out !== 16'h5678 || param_upd !== 1'b1 || frame_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_strobe_wins: got kp=%h upd=%b err=%b want 5678 1 0", kp_out, param_upd, frame_err);
      end
      idle(1);
   endtask

   task automatic test_back_to_back;
      int upd_before;
      upd_before = upd_cnt;
      frame(8'h00, 16'h0001);
      frame(8'h01, 16'h0002);
      vec_cnt++;
      if (param_upd !== 1'b1 || kp_out !== 16'h0001 || ki_out !== 16'h0002) begin
         err_cnt++;
         $display("FAIL b2b_regs: got upd=%b kp=%h ki=%h want 1 0001 0002", param_upd, kp_out, ki_out);
      end
      idle(2);
      vec_cnt++;
      if (upd_cnt - upd_before !== 2) begin
         err_cnt++;
         $display("FAIL b2b_pulses: got %0d want 2", upd_cnt - upd_before);
      end
      vec_cnt++;
      if (kd_out !== 16'h1234) begin
         err_cnt++;
         $display("FAIL b2b_kd_hold: got %h want 1234", kd_out);
      end
   endtask

   task automatic test_reset_mid;
      drive(8'hA5);
      drive(8'h03);
      drive(8'hAA);
      #2;
      rst_in = 1'b1;
      #1;
      vec_cnt++;
      if ({kp_out, ki_out, kd_out, setpoint_out} !== 64'h0 || {param_upd, frame_err, busy} !== 3'b000) begin
         err_cnt++;
         $display("FAIL reset_mid: got regs=%h flags=%b want 0 000", {kp_out, ki_out, kd_out, setpoint_out}, {param_upd, frame_err, busy});
      end
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      idle(1);
      frame(8'h01, 16'h002A);
      vec_cnt++;
      if (ki_out !== 16'h002A || param_upd !== 1'b1 || setpoint_out !== 16'h0) begin
         err_cnt++;
         $display("FAIL reset_recover: got ki=%h upd=%b sp=%h want 002A 1 0", ki_out, param_upd, setpoint_out);
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_write();
`ifdef PARAM_CHECKSUM_EN
      test_checksum();
`endif
      test_bad_addr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      vec_cnt++;
      if (both_cnt !== 0) begin
         err_cnt++;
         $display("FAIL upd_err_overlap: got %0d want 0", both_cnt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
